change_dispense_ctrl: RTL

- Parametrised successor to the fixed five-case change dispenser.
- Accepts any change amount, given in nickel units, through a valid/ready handshake.
- Plans a dime-first payout against the live coin inventory and refuses requests it cannot pay exactly.
- Ejects one coin per clock and supports inventory restocking. Sits between the vending FSM and the coin ejector solenoids.

---
 rtl/change_dispense_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/change_dispense_ctrl.sv
// Change dispenser: plans a dime-first payout against live inventory, ejects one coin per clock.
// Latency: CHECK one cycle after accept, coin pulses from the second cycle, done/fail one cycle after the last coin.
// Backpressure: req_ready only in IDLE; restock_ack only in IDLE with no competing request (caller holds restock).
module change_dispense_ctrl #(
    parameter int CNT_W       = 8,
    parameter int AMT_W       = 6,
    parameter int NICKEL_INIT = 0,
    parameter int DIME_INIT   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             restock_valid,
    input  logic             restock_dime,
    input  logic [CNT_W-1:0] restock_qty,
    output logic             restock_ack,
    output logic             nickel_out,
    output logic             dime_out,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] nickel_count,
    output logic [CNT_W-1:0] dime_count
);

    // Common width wide enough to compare inventory counts against plan values.
    localparam int CW = ((CNT_W > AMT_W) ? CNT_W : AMT_W) + 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CHECK      = 3'd1,
        PAY_DIME   = 3'd2,
        PAY_NICKEL = 3'd3,
        DONE_ST    = 3'd4,
        FAIL_ST    = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AMT_W-1:0] amt_r;
    logic [AMT_W-1:0] d_plan_r;
    logic [AMT_W:0]   n_plan_r;

    logic [AMT_W-1:0] d_plan_c;
    logic [AMT_W:0]   n_plan_c;
    logic [CW-1:0]    dime_w;
    logic [CW-1:0]    half_w;
    logic [CW-1:0]    nick_w;
    logic [CW-1:0]    nplan_w;
    logic             plan_short;

    logic             nickel_out_d;
    logic             dime_out_d;
    logic             done_d;
    logic             fail_d;

    logic [CNT_W:0]   nickel_sum;
    logic [CNT_W:0]   dime_sum;
    logic [CNT_W-1:0] nickel_sat;
    logic [CNT_W-1:0] dime_sat;

    // Payout plan: take as many dimes as possible, remainder in nickels, then see if nickels cover it.
    always_comb begin
        dime_w     = CW'(dime_count);
        half_w     = CW'(amt_r >> 1);
        d_plan_c   = (dime_w < half_w) ? AMT_W'(dime_count) : (amt_r >> 1);
        n_plan_c   = {1'b0, amt_r} - {d_plan_c, 1'b0};
        nick_w     = CW'(nickel_count);
        nplan_w    = CW'(n_plan_c);
        plan_short = (nplan_w > nick_w);
    end

    // Saturating restock sums; a carry out means the counter would wrap, so clamp to all ones.
    always_comb begin
        nickel_sum = {1'b0, nickel_count} + {1'b0, restock_qty};
        dime_sum   = {1'b0, dime_count} + {1'b0, restock_qty};
        nickel_sat = nickel_sum[CNT_W] ? {CNT_W{1'b1}} : nickel_sum[CNT_W-1:0];
        dime_sat   = dime_sum[CNT_W] ? {CNT_W{1'b1}} : dime_sum[CNT_W-1:0];
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; plan counters reaching one means this is the last coin of that kind.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (amt_r == '0) begin
                    state_nxt = DONE_ST;
                end else if (plan_short) begin
                    state_nxt = FAIL_ST;
                end else if (d_plan_c != '0) begin
                    state_nxt = PAY_DIME;
                end else begin
                    state_nxt = PAY_NICKEL;
                end
            end
            PAY_DIME: begin
                if (d_plan_r == AMT_W'(1)) begin
                    state_nxt = (n_plan_r != '0) ? PAY_NICKEL : DONE_ST;
                end
            end
            PAY_NICKEL: begin
                if (n_plan_r == (AMT_W+1)'(1)) begin
                    state_nxt = DONE_ST;
                end
            end
            DONE_ST: state_nxt = IDLE;
            FAIL_ST: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: handshakes from the current state, pulses pre-decoded from the next state.
    always_comb begin
        req_ready    = (state == IDLE);
        restock_ack  = restock_valid && (state == IDLE) && !req_valid;
        dime_out_d   = (state_nxt == PAY_DIME);
        nickel_out_d = (state_nxt == PAY_NICKEL);
        done_d       = (state_nxt == DONE_ST);
        fail_d       = (state_nxt == FAIL_ST);
    end

    // Registered pulses, high in exactly the cycles spent in the matching state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nickel_out <= 1'b0;
            dime_out   <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            nickel_out <= nickel_out_d;
            dime_out   <= dime_out_d;
            done       <= done_d;
            fail       <= fail_d;
        end
    end

    // Request latch and plan counters, loaded in CHECK and counted down while paying.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            amt_r    <= '0;
            d_plan_r <= '0;
            n_plan_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        amt_r <= req_amount;
                    end
                end
                CHECK: begin
                    d_plan_r <= d_plan_c;
                    n_plan_r <= n_plan_c;
                end
                PAY_DIME:   d_plan_r <= d_plan_r - AMT_W'(1);
                PAY_NICKEL: n_plan_r <= n_plan_r - (AMT_W+1)'(1);
                default: ;
            endcase
        end
    end

    // Inventory: restock only when acknowledged, decrement alongside each eject pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nickel_count <= CNT_W'(NICKEL_INIT);
            dime_count   <= CNT_W'(DIME_INIT);
        end else if (restock_ack) begin
            if (restock_dime) begin
                dime_count <= dime_sat;
            end else begin
                nickel_count <= nickel_sat;
            end
        end else if (state == PAY_DIME) begin
            dime_count <= dime_count - CNT_W'(1);
        end else if (state == PAY_NICKEL) begin
            nickel_count <= nickel_count - CNT_W'(1);
        end
    end

endmodule
